rd_burst_arbiter: RTL and testbench

Shares one memory-side burst read port between NREQ input caches. Each cache issues a fixed-length burst request (start address, NTFR beats of 64 bits). The arbiter grants requests round-robin, forwards the granted address to the memory port, and steers beat-enable pulses back to the granted cache only. Data is broadcast to all caches; only the granted cache sees beat enables.

---
 rtl/rd_burst_arbiter_if.sv | 33 +++
 rtl/rd_burst_arbiter.sv | 149 ++++++++++++++
 tb/tb_rd_burst_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rd_burst_arbiter_if.sv
// rd_burst_arbiter_if: bundles the cache-side and memory-side burst read
// signals of rd_burst_arbiter.
//   Cache side : rreq (per-requester burst request), radr (packed start
//                addresses, requester i at [i*AW +: AW]), rack (per-requester
//                beat enable), rdata (broadcast beat data).
//   Memory side: mreq/madr (burst request and start address), mack (beat
//                enable, first one also acknowledges the request), mdata.
// Modport slave is the arbiter's view; modport master is the environment's
// view (caches plus memory).
interface rd_burst_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 24,
  parameter int DW   = 64
);
  logic [NREQ-1:0]    rreq;
  logic [NREQ*AW-1:0] radr;
  logic [NREQ-1:0]    rack;
  logic [DW-1:0]      rdata;
  logic               mreq;
  logic [AW-1:0]      madr;
  logic               mack;
  logic [DW-1:0]      mdata;

  modport slave (
    input  rreq, radr, mack, mdata,
    output rack, rdata, mreq, madr
  );

  modport master (
    output rreq, radr, mack, mdata,
    input  rack, rdata, mreq, madr
  );
endinterface

// File: rtl/rd_burst_arbiter.sv
// rd_burst_arbiter: shares one memory burst read port between NREQ caches.
// Requests are granted round-robin from IDLE, the winner's start address is
// forwarded on madr/mreq, and memory beat enables are steered to the granted
// cache only. Beat data is broadcast to every cache with zero latency.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   bus      - rd_burst_arbiter_if.slave (cache side and memory side)
//   busy     - high while a request or burst is in flight
//   gid      - index of the current grant (last grant while idle)
//   err      - sticky flag: memory beat enable seen while idle
module rd_burst_arbiter #(
  parameter int NREQ = 4,
  parameter int NTFR = 64,
  parameter int AW   = 24,
  parameter int DW   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  rd_burst_arbiter_if.slave       bus,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] gid,
  output logic                    err
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(NTFR) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] gid_q, gid_d;
  logic          mreq_q, mreq_d;
  logic [AW-1:0] madr_q, madr_d;
  logic          err_q, err_d;

  logic [GW-1:0] sel;
  logic          sel_vld;
  logic [AW-1:0] radr_a [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_radr
    assign radr_a[gi] = bus.radr[gi*AW +: AW];
  end

  // Round-robin pick: scan from the farthest candidate to the nearest so the
  // requester right after last_q overwrites everyone else and wins.
  always_comb begin
    int idx;
    idx     = 0;
    sel     = last_q;
    sel_vld = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.rreq[idx]) begin
        sel     = GW'(idx);
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gid_d   = gid_q;
    mreq_d  = mreq_q;
    madr_d  = madr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // No grant is active, so any beat enable here is stray.
        if (bus.mack) err_d = 1'b1;
        if (sel_vld) begin
          gid_d   = sel;
          madr_d  = radr_a[sel];
          mreq_d  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // First beat enable doubles as the request acknowledge.
        if (bus.mack) begin
          mreq_d = 1'b0;
          cnt_d  = CW'(1);
          if (NTFR == 1) begin
            state_d = IDLE;
            last_d  = gid_q;
          end else begin
            state_d = BURST;
          end
        end
      end
      BURST: begin
        if (bus.mack) begin
          if (cnt_q == CW'(NTFR - 1)) begin
            state_d = IDLE;
            last_d  = gid_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= GW'(NREQ - 1);
      gid_q   <= '0;
      mreq_q  <= 1'b0;
      madr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      mreq_q  <= mreq_d;
      madr_q  <= madr_d;
      err_q   <= err_d;
    end
  end

  // Beat enables go only to the granted cache, and only while a grant is live.
  always_comb begin
    bus.rack = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.rack[i] = bus.mack && (state_q != IDLE) && (gid_q == GW'(i));
    end
  end

  assign bus.rdata = bus.mdata;
  assign bus.mreq  = mreq_q;
  assign bus.madr  = madr_q;
  assign busy      = (state_q != IDLE);
  assign gid       = gid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rd_burst_arbiter.sv
module tb_rd_burst_arbiter;
  localparam int NREQ = 4;
  localparam int NTFR = 64;
  localparam int AW   = 24;
  localparam int DW   = 64;

  logic       clk;
  logic       rst;
  logic       busy, busy1;
  logic [1:0] gid, gid1;
  logic       err, err1;

  int checks   = 0;
  int failures = 0;

  int         exp_gid_q[$];
  logic [23:0] exp_adr_q[$];

  rd_burst_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
  rd_burst_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus1 ();

  rd_burst_arbiter #(.NREQ(NREQ), .NTFR(NTFR), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .gid(gid), .err(err)
  );

  rd_burst_arbiter #(.NREQ(NREQ), .NTFR(1), .AW(AW), .DW(DW)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .gid(gid1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.rreq = '0;  bus.radr = '0;  bus.mack = 1'b0;  bus.mdata = '0;
    bus1.rreq = '0; bus1.radr = '0; bus1.mack = 1'b0; bus1.mdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.mreq !== 1'b0) begin failures++; $display("FAIL reset_mreq got=%b want=0", bus.mreq); end
    checks++; if (bus.madr !== 24'h0) begin failures++; $display("FAIL reset_madr got=%h want=000000", bus.madr); end
    checks++; if (bus.rack !== 4'b0) begin failures++; $display("FAIL reset_rack got=%b want=0000", bus.rack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (gid !== 2'd0) begin failures++; $display("FAIL reset_gid got=%0d want=0", gid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
    $display("reset done mreq=%b busy=%b gid=%0d err=%b", bus.mreq, busy, gid, err);
  endtask

  // Waits for a grant, checks it against the scoreboard, then serves a full
  // burst. drop_mode: 0 drop granted rreq bit, 1 hold all, 2 drop all.
  task automatic run_grant(input int exp_steps, input int gap, input int drop_mode);
    int          steps;
    int          g;
    int          bad;
    logic [23:0] a;
    logic [63:0] d;
    logic [3:0]  exp_rack;
    steps = 0;
    do begin
      @(posedge clk); #1 bus.mack = 1'b0;
      steps++;
      @(negedge clk);
    end while (bus.mreq !== 1'b1 && steps < 50);
    checks++;
    if (bus.mreq !== 1'b1) begin
      failures++;
      $display("FAIL grant_timeout mreq=%b after %0d cycles want=1", bus.mreq, steps);
      return;
    end
    checks++;
    if (exp_gid_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_grant gid=%0d scoreboard empty", gid);
      return;
    end
    g = exp_gid_q.pop_front();
    a = exp_adr_q.pop_front();
    checks++; if (gid !== 2'(g)) begin failures++; $display("FAIL grant_gid got=%0d want=%0d", gid, g); end
    checks++; if (bus.madr !== a) begin failures++; $display("FAIL grant_madr got=%h want=%h", bus.madr, a); end
    checks++; if (steps !== exp_steps) begin failures++; $display("FAIL grant_latency got=%0d want=%0d", steps, exp_steps); end
    exp_rack = 4'b0001 << g;
    bad = 0;
    for (int b = 0; b < NTFR; b++) begin
      if (b > 0) begin
        repeat (gap) begin
          @(posedge clk); #1 bus.mack = 1'b0;
          @(negedge clk);
          if (bus.rack !== 4'b0 || busy !== 1'b1 || bus.mreq !== 1'b0) bad++;
        end
      end
      d = {$urandom, $urandom};
      @(posedge clk); #1 bus.mack = 1'b1; bus.mdata = d;
      if (b == 0) begin
        if (drop_mode == 0) bus.rreq[g] = 1'b0;
        else if (drop_mode == 2) bus.rreq = '0;
      end
      @(negedge clk);
      if (bus.rack !== exp_rack || bus.rdata !== d || busy !== 1'b1) bad++;
      if (b > 0 && bus.mreq !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL burst_beats bad_samples=%0d want=0 gid=%0d", bad, g); end
    @(posedge clk); #1 bus.mack = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL burst_end_busy got=%b want=0", busy); end
    checks++; if (bus.mreq !== 1'b0) begin failures++; $display("FAIL idle_gap_mreq got=%b want=0", bus.mreq); end
    $display("grant gid=%0d madr=%h beats=%0d gap=%0d", g, a, NTFR, gap);
  endtask

  task automatic test_single();
    bus.radr[2*AW +: AW] = 24'h001200;
    exp_gid_q.push_back(2); exp_adr_q.push_back(24'h001200);
    bus.rreq = 4'b0100;
    run_grant(1, 0, 0);
  endtask

  task automatic test_simultaneous();
    test_reset();
    bus.radr = {24'hA00300, 24'hA00200, 24'hA00100, 24'hA00000};
    exp_gid_q.push_back(0); exp_adr_q.push_back(24'hA00000);
    exp_gid_q.push_back(1); exp_adr_q.push_back(24'hA00100);
    exp_gid_q.push_back(2); exp_adr_q.push_back(24'hA00200);
    exp_gid_q.push_back(3); exp_adr_q.push_back(24'hA00300);
    exp_gid_q.push_back(0); exp_adr_q.push_back(24'hA00000);
    bus.rreq = 4'b1111;
    for (int i = 0; i < 4; i++) run_grant(1, 0, 1);
    run_grant(1, 0, 2);
  endtask

  task automatic test_rotation_skip();
    bus.radr = {24'hB00300, 24'hB00200, 24'hB00100, 24'hB00000};
    exp_gid_q.push_back(1); exp_adr_q.push_back(24'hB00100);
    bus.rreq = 4'b0010;
    run_grant(1, 0, 0);
    exp_gid_q.push_back(3); exp_adr_q.push_back(24'hB00300);
    exp_gid_q.push_back(0); exp_adr_q.push_back(24'hB00000);
    bus.rreq = 4'b1001;
    run_grant(1, 0, 0);
    run_grant(1, 0, 0);
  endtask

  task automatic test_mack_gaps();
    bus.radr[1*AW +: AW] = 24'hC0FFEE;
    exp_gid_q.push_back(1); exp_adr_q.push_back(24'hC0FFEE);
    bus.rreq = 4'b0010;
    run_grant(1, 2, 0);
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] d;
    int          g;
    logic [23:0] a;
    int          bad;
    bus.radr = {24'hD00300, 24'hD00200, 24'hD00100, 24'hD00000};
    exp_gid_q.push_back(2); exp_adr_q.push_back(24'hD00200);
    bus.rreq = 4'b0100;
    @(posedge clk); #1;
    @(negedge clk);
    g = exp_gid_q.pop_front();
    a = exp_adr_q.pop_front();
    checks++; if (bus.mreq !== 1'b1 || gid !== 2'(g)) begin failures++; $display("FAIL rmb_grant mreq=%b gid=%0d want mreq=1 gid=%0d", bus.mreq, gid, g); end
    checks++; if (bus.madr !== a) begin failures++; $display("FAIL rmb_madr got=%h want=%h", bus.madr, a); end
    bad = 0;
    for (int b = 0; b < 10; b++) begin
      d = {$urandom, $urandom};
      @(posedge clk); #1 bus.mack = 1'b1; bus.mdata = d;
      if (b == 0) bus.rreq = '0;
      @(negedge clk);
      if (bus.rack !== 4'b0100 || bus.rdata !== d) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rmb_beats bad_samples=%0d want=0", bad); end
    @(posedge clk); #1 bus.mack = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.mreq !== 1'b0) begin failures++; $display("FAIL rmb_mreq got=%b want=0", bus.mreq); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmb_busy got=%b want=0", busy); end
    checks++; if (gid !== 2'd0) begin failures++; $display("FAIL rmb_gid got=%0d want=0", gid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rmb_err_clear got=%b want=0", err); end
    // stray beat after reset
    @(posedge clk); #1 bus.mack = 1'b1; bus.mdata = 64'h5;
    @(negedge clk);
    checks++; if (bus.rack !== 4'b0) begin failures++; $display("FAIL stray_rack got=%b want=0000", bus.rack); end
    @(posedge clk); #1 bus.mack = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL stray_err got=%b want=1", err); end
    $display("reset mid-burst after 10 beats, stray mack err=%b", err);
    exp_gid_q.push_back(0); exp_adr_q.push_back(24'hD00000);
    bus.rreq = 4'b1111;
    run_grant(1, 0, 2);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", err); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_rst_clear got=%b want=0", err); end
  endtask

  task automatic test_ntfr1();
    int          steps;
    int          g;
    logic [23:0] a;
    logic [63:0] d;
    logic [3:0]  exp_rack;
    bus1.radr = {24'hE00300, 24'hE00200, 24'hE00100, 24'hE00000};
    for (int i = 0; i < 4; i++) begin
      exp_gid_q.push_back(i % 2);
      exp_adr_q.push_back((i % 2) == 0 ? 24'hE00000 : 24'hE00100);
    end
    bus1.rreq = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      steps = 0;
      do begin
        @(posedge clk); #1 bus1.mack = 1'b0;
        steps++;
        @(negedge clk);
      end while (bus1.mreq !== 1'b1 && steps < 20);
      g = exp_gid_q.pop_front();
      a = exp_adr_q.pop_front();
      checks++; if (bus1.mreq !== 1'b1 || steps !== 1) begin failures++; $display("FAIL n1_grant mreq=%b steps=%0d want mreq=1 steps=1", bus1.mreq, steps); end
      checks++; if (gid1 !== 2'(g)) begin failures++; $display("FAIL n1_gid got=%0d want=%0d", gid1, g); end
      checks++; if (bus1.madr !== a) begin failures++; $display("FAIL n1_madr got=%h want=%h", bus1.madr, a); end
      d = {$urandom, $urandom};
      exp_rack = 4'b0001 << g;
      @(posedge clk); #1 bus1.mack = 1'b1; bus1.mdata = d;
      if (i == 3) bus1.rreq = '0;
      @(negedge clk);
      checks++; if (bus1.rack !== exp_rack || bus1.rdata !== d) begin failures++; $display("FAIL n1_beat rack=%b rdata=%h want rack=%b rdata=%h", bus1.rack, bus1.rdata, exp_rack, d); end
      @(posedge clk); #1 bus1.mack = 1'b0;
      @(negedge clk);
      checks++; if (busy1 !== 1'b0 || bus1.mreq !== 1'b0) begin failures++; $display("FAIL n1_idle busy=%b mreq=%b want 0 0", busy1, bus1.mreq); end
      $display("ntfr1 grant gid=%0d madr=%h", g, a);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_rotation_skip();
    test_mack_gaps();
    test_reset_mid_burst();
    test_ntfr1();
    checks++;
    if (exp_gid_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_gid_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
